// File: rtl/bus_source_sequencer_pkg.sv
// Shared types and constants for the bus source sequencer: FSM states,
// source count and the named bus-source codes.
package bus_source_sequencer_pkg;

  localparam int NUM_SOURCES = 24;
  localparam int CODE_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } seq_state_e;

  localparam logic [CODE_W-1:0] SRC_R0     = 5'd0;
  localparam logic [CODE_W-1:0] SRC_R1     = 5'd1;
  localparam logic [CODE_W-1:0] SRC_R2     = 5'd2;
  localparam logic [CODE_W-1:0] SRC_R3     = 5'd3;
  localparam logic [CODE_W-1:0] SRC_R4     = 5'd4;
  localparam logic [CODE_W-1:0] SRC_R5     = 5'd5;
  localparam logic [CODE_W-1:0] SRC_R6     = 5'd6;
  localparam logic [CODE_W-1:0] SRC_R7     = 5'd7;
  localparam logic [CODE_W-1:0] SRC_R8     = 5'd8;
  localparam logic [CODE_W-1:0] SRC_R9     = 5'd9;
  localparam logic [CODE_W-1:0] SRC_R10    = 5'd10;
  localparam logic [CODE_W-1:0] SRC_R11    = 5'd11;
  localparam logic [CODE_W-1:0] SRC_R12    = 5'd12;
  localparam logic [CODE_W-1:0] SRC_R13    = 5'd13;
  localparam logic [CODE_W-1:0] SRC_R14    = 5'd14;
  localparam logic [CODE_W-1:0] SRC_R15    = 5'd15;
  localparam logic [CODE_W-1:0] SRC_HI     = 5'd16;
  localparam logic [CODE_W-1:0] SRC_LO     = 5'd17;
  localparam logic [CODE_W-1:0] SRC_ZHIGH  = 5'd18;
  localparam logic [CODE_W-1:0] SRC_ZLOW   = 5'd19;
  localparam logic [CODE_W-1:0] SRC_PC     = 5'd20;
  localparam logic [CODE_W-1:0] SRC_MDR    = 5'd21;
  localparam logic [CODE_W-1:0] SRC_INPORT = 5'd22;
  localparam logic [CODE_W-1:0] SRC_C      = 5'd23;

  // Codes 24..31 have no physical source behind them.
  function automatic logic code_is_legal(input logic [CODE_W-1:0] code);
    return (code <= SRC_C);
  endfunction

endpackage

// File: rtl/bus_source_sequencer_onehot.sv
// Combinational 5-to-24 one-hot expansion of a bus-source code; codes with
// no source behind them expand to all-zero.
module bus_src_onehot
  import bus_source_sequencer_pkg::*;
(
  input  logic [CODE_W-1:0]      code_i,
  output logic [NUM_SOURCES-1:0] onehot_o
);

  // Expand the code, suppressing every illegal code.
  always_comb begin
    onehot_o = '0;
    if (code_is_legal(code_i)) begin
      onehot_o[code_i] = 1'b1;
    end else begin
      onehot_o = '0;
    end
  end

endmodule

// File: rtl/bus_source_sequencer.sv
// Bus source sequencer: grants one bus source at a time and inserts a
// break-before-make dead time of GAP_CYCLES between sources.
module bus_source_sequencer
  import bus_source_sequencer_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   sel_valid,
  input  logic [CODE_W-1:0]      sel_code,
  output logic [NUM_SOURCES-1:0] out_en,
  output logic [CODE_W-1:0]      src_code,
  output logic                   bus_busy,
  output logic                   code_err
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  seq_state_e             state_q;
  logic [NUM_SOURCES-1:0] out_en_q;
  logic [CODE_W-1:0]      src_code_q;
  logic                   bus_busy_q;
  logic                   code_err_q;
  logic [3:0]             gap_cnt_q;

  logic [NUM_SOURCES-1:0] req_onehot_d;
  logic                   req_legal_d;
  logic                   req_err_d;
  logic                   req_hold_d;

  bus_src_onehot u_onehot (
    .code_i   (sel_code),
    .onehot_o (req_onehot_d)
  );

  assign req_legal_d = sel_valid && code_is_legal(sel_code);
  assign req_err_d   = sel_valid && !code_is_legal(sel_code);
  // Only meaningful in DRIVE, where src_code_q always holds a legal code.
  assign req_hold_d  = sel_valid && (sel_code == src_code_q);

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      out_en_q   <= '0;
      src_code_q <= 5'd0;
      bus_busy_q <= 1'b0;
      code_err_q <= 1'b0;
      gap_cnt_q  <= 4'd0;
    end else begin
      code_err_q <= req_err_d;
      case (state_q)
        ST_IDLE: begin
          if (req_legal_d) begin
            state_q    <= ST_DRIVE;
            out_en_q   <= req_onehot_d;
            src_code_q <= sel_code;
            bus_busy_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DRIVE: begin
          if (req_hold_d) begin
            state_q <= ST_DRIVE;
          end else begin
            state_q    <= ST_GAP;
            out_en_q   <= '0;
            src_code_q <= 5'd0;
            bus_busy_q <= 1'b0;
            gap_cnt_q  <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          // Only the inputs seen in the last dead cycle decide the next source.
          if (gap_cnt_q == 4'd0) begin
            if (req_legal_d) begin
              state_q    <= ST_DRIVE;
              out_en_q   <= req_onehot_d;
              src_code_q <= sel_code;
              bus_busy_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          out_en_q   <= '0;
          src_code_q <= 5'd0;
          bus_busy_q <= 1'b0;
          gap_cnt_q  <= 4'd0;
        end
      endcase
    end
  end

  assign out_en   = out_en_q;
  assign src_code = src_code_q;
  assign bus_busy = bus_busy_q;
  assign code_err = code_err_q;

endmodule

// File: doc/bus_source_sequencer.md
BUS_SOURCE_SEQUENCER -- requirements
Module: bus_source_sequencer

Interface
REQ-001 Parameter GAP_CYCLES, default 1, sets the dead-time cycles between bus sources (legal range 1..15).
REQ-002 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port clr  input  1  reset, synchronous, active-high.
REQ-004 Port sel_valid  input  1  requester asks for a bus source this cycle.
REQ-005 Port sel_code  input  5  requested source code; 0..15 = R0..R15, 16 HI, 17 LO, 18 ZHIGH, 19 ZLOW, 20 PC, 21 MDR, 22 INPORT, 23 C.
REQ-006 Port out_en  output  24  registered one-hot bus-drive enables; bit n enables the source with code n.
REQ-007 Port src_code  output  5  registered code of the source currently driving; 0 when none.
REQ-008 Port bus_busy  output  1  registered; 1 exactly when out_en is non-zero.
REQ-009 Port code_err  output  1  registered one-cycle pulse flagging an illegal code (24..31) sampled with sel_valid=1.

Function
REQ-010 The FSM SHALL have the states IDLE, DRIVE and GAP; out_en SHALL be non-zero only in DRIVE.
REQ-011 In DRIVE, out_en SHALL have exactly one bit set, at index src_code; out_en SHALL never have more than one bit set.
REQ-012 IDLE with sel_valid=1 and a legal code SHALL go to DRIVE on the next edge, latching the code (latency 1 cycle).
REQ-013 IDLE with sel_valid=0 SHALL stay in IDLE.
REQ-014 DRIVE with sel_valid=1 and sel_code equal to the latched code SHALL stay in DRIVE with out_en unchanged.
REQ-015 DRIVE with sel_valid=0, or with a different code (legal or illegal), SHALL go to GAP; out_en SHALL read 0 for GAP_CYCLES cycles (break-before-make).
REQ-016 On entry to GAP, a gap counter SHALL load GAP_CYCLES-1 and decrement each cycle; the counter SHALL be 4 bits and SHALL never wrap below 0.
REQ-017 When the gap counter is 0, GAP SHALL sample the inputs on that edge:
- legal code with sel_valid=1 -> DRIVE with that code;
- otherwise -> IDLE.
REQ-018 Requests arriving mid-GAP SHALL NOT be queued; only the inputs present in the final GAP cycle count.
REQ-019 Any cycle with sel_valid=1 and sel_code>=24 SHALL assert code_err on the next cycle for exactly one cycle, in every state.
REQ-020 An illegal code SHALL never set any out_en bit.
REQ-021 src_code SHALL read 0 in IDLE and GAP.
REQ-022 A change of code with no GAP in between SHALL be impossible; every source handover SHALL show at least GAP_CYCLES cycles of all-zero out_en.

Reset
REQ-023 With clr=1 at an edge, the block SHALL enter IDLE and set out_en=0, src_code=0, bus_busy=0, code_err=0 and gap counter=0.
REQ-024 clr SHALL override all other inputs, including mid-DRIVE and mid-GAP; there SHALL be no pending request after reset.
REQ-025 The first request accepted after clr deasserts SHALL follow REQ-012 with no extra latency.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, NUM_SOURCES=24, and named source-code constants (R0..R15, HI, LO, ZHIGH, ZLOW, PC, MDR, INPORT, C).
REQ-027 The 5-to-24 one-hot expansion SHALL be a combinational sub-module, bus_src_onehot, whose output is all-zero for codes 24..31; the FSM and output registers SHALL live in the top level.

Verification
REQ-028 clr, then sel_valid=1, code=20 -> out_en=0x100000, src_code=20, bus_busy=1 on the next cycle; held request -> out_en stable.
REQ-029 Driving code 3, then switch to code 21 with GAP_CYCLES=1 -> one cycle with out_en=0, then out_en=0x200000.
REQ-030 GAP_CYCLES=3, driving code 16, then sel_valid=0 -> out_en=0 for 3 cycles, then IDLE with bus_busy=0.
REQ-031 IDLE with sel_valid=1, code=27 -> code_err=1 for one cycle, out_en stays 0, state stays IDLE; the same stimulus during DRIVE -> GAP entered and code_err pulses.
REQ-032 clr asserted mid-GAP with a legal request pending -> next cycle all outputs 0, state IDLE, no DRIVE follows until a new request.
REQ-033 Random stimulus, 10k cycles -> assertion checks that out_en is one-hot-or-zero every cycle and that every handover has >=GAP_CYCLES zero cycles.
